// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequences a serial chain of CHAIN_LEN falling-edge mux-DFF cells.
// Read  (load=0): one-cycle parallel capture, then streams the chain out one bit per
//                 accepted handshake while recirculating so contents are preserved.
// Write (load=1): shifts host_si into the chain while the old contents stream out.
// Optional feature: define SCAN_PARITY_EN to keep a running XOR of the accepted bits;
// without it parity is tied low and no parity register exists.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load,
  input  logic             host_si,
  input  logic             chain_so,
  output logic             chain_si,
  output logic             chain_cap,
  output logic             chain_shift,
  output logic             so_valid,
  output logic             so_data,
  input  logic             so_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             parity
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic             load_q, load_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             chain_cap_q, chain_cap_d;
  logic             so_valid_q, so_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  // A bit is accepted only while streaming and the host takes it this cycle.
  assign accept = (state_q == SHIFT) && so_ready;

  // Next-state logic; Moore outputs are decoded from the next state so they register.
  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_d    = load;
          bit_cnt_d = '0;
          state_d   = load ? SHIFT : CAPTURE;
        end
      end
      CAPTURE: state_d = SHIFT;
      SHIFT: begin
        if (so_ready) begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
          if (bit_cnt_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    chain_cap_d = (state_d == CAPTURE);
    so_valid_d  = (state_d == SHIFT);
    busy_d      = (state_d == CAPTURE) || (state_d == SHIFT);
    done_d      = (state_d == DONE);
  end

  // Single state register holding the FSM, its registered outputs and the bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      load_q      <= 1'b0;
      bit_cnt_q   <= '0;
      chain_cap_q <= 1'b0;
      so_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      bit_cnt_q   <= bit_cnt_d;
      chain_cap_q <= chain_cap_d;
      so_valid_q  <= so_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef SCAN_PARITY_EN
  logic parity_q, parity_d;

  // Running XOR of accepted bits, cleared when an operation is accepted.
  always_comb begin
    parity_d = parity_q;
    if ((state_q == IDLE) && start) begin
      parity_d = 1'b0;
    end else if (accept) begin
      parity_d = parity_q ^ chain_so;
    end
  end

  // Parity register; the final value holds until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

  // Shift enable follows the handshake combinationally; cells act on the next falling edge.
  assign chain_shift = accept;
  assign chain_si    = load_q ? host_si : chain_so;
  assign so_data     = chain_so;
  assign chain_cap   = chain_cap_q;
  assign so_valid    = so_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Testbench for scan_chain_ctrl with an 8-cell falling-edge chain model.
// A behavioural model tracks the operation phase, accepted bit count, parity and
// the chain contents as a plain word; one compare process checks every cycle.
module tb_scan_chain_ctrl;

  localparam int N  = 8;
  localparam int CW = 4;

  // Phases of an operation in the reference model
  localparam int P_IDLE = 0;
  localparam int P_CAP  = 1;
  localparam int P_SHIFT = 2;
  localparam int P_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          load = 1'b0;
  logic          host_si = 1'b0;
  logic          chain_so;
  logic          chain_si;
  logic          chain_cap;
  logic          chain_shift;
  logic          so_valid;
  logic          so_data;
  logic          so_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_cnt;
  logic          parity;

  logic [N-1:0]  cells  = '0;
  logic [N-1:0]  cell_d = '0;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model state
  int           m_phase = P_IDLE;
  logic         m_load  = 1'b0;
  logic [N-1:0] m_cur   = '0;
  int           m_cnt   = 0;
  logic         m_par   = 1'b0;
  logic         m_idle  = 1'b1;

  // Observations gathered from the DUT for directed checks
  logic [N-1:0] act_word   = '0;
  int           acc_cnt    = 0;
  int           cap_cycles = 0;
  int           done_count = 0;

  logic host_seq [N] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic bp_pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load       (load),
    .host_si    (host_si),
    .chain_so   (chain_so),
    .chain_si   (chain_si),
    .chain_cap  (chain_cap),
    .chain_shift(chain_shift),
    .so_valid   (so_valid),
    .so_data    (so_data),
    .so_ready   (so_ready),
    .busy       (busy),
    .done       (done),
    .bit_cnt    (bit_cnt),
    .parity     (parity)
  );

  always #5 clk = ~clk;

  // Count rising edges so latencies can be measured in cycles
  always @(posedge clk) cyc <= cyc + 1;

  // The flop chain itself: capture D in parallel or shift toward cell N-1 on the falling edge
  assign chain_so = cells[N-1];
  always @(negedge clk) begin
    if (chain_cap) cells <= cell_d;
    else if (chain_shift) cells <= {cells[N-2:0], chain_si};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model using this cycle's inputs
  always @(posedge clk) begin
    logic exp_par;
    logic bitv;
    #2;
    if (rst) begin
      m_phase = P_IDLE;
      m_load  = 1'b0;
      m_cnt   = 0;
      m_par   = 1'b0;
    end
`ifdef SCAN_PARITY_EN
    exp_par = m_par;
`else
    exp_par = 1'b0;
`endif
    checkOutput("chain_cap", chain_cap, m_phase == P_CAP);
    checkOutput("so_valid", so_valid, m_phase == P_SHIFT);
    checkOutput("busy", busy, (m_phase == P_CAP) || (m_phase == P_SHIFT));
    checkOutput("done", done, m_phase == P_DONE);
    checkOutput("chain_shift", chain_shift, (m_phase == P_SHIFT) && so_ready);
    checkOutput("bit_cnt", bit_cnt, m_cnt);
    checkOutput("parity", parity, exp_par);
    checkOutput("chain_si", chain_si, m_load ? host_si : m_cur[N-1]);
    if (m_phase == P_SHIFT) checkOutput("so_data", so_data, m_cur[N-1]);
    if (done) done_count++;
    if (chain_cap) cap_cycles++;
    if (!rst) begin
      case (m_phase)
        P_IDLE: begin
          if (start) begin
            m_load     = load;
            m_cnt      = 0;
            m_par      = 1'b0;
            acc_cnt    = 0;
            act_word   = '0;
            cap_cycles = 0;
            m_phase    = load ? P_SHIFT : P_CAP;
          end
        end
        P_CAP: begin
          m_cur   = cell_d;
          m_phase = P_SHIFT;
        end
        P_SHIFT: begin
          if (so_ready) begin
            bitv     = m_cur[N-1];
            act_word = {act_word[N-2:0], so_data};
            acc_cnt++;
            m_par    = m_par ^ bitv;
            m_cur    = {m_cur[N-2:0], m_load ? host_si : bitv};
            m_cnt++;
            if (m_cnt == N) m_phase = P_DONE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
    m_idle = (m_phase == P_IDLE);
  end

  // Drive one cycle of inputs just after the rising edge
  task automatic applyStimulus(input logic st, input logic ld, input logic hs, input logic rdy);
    @(posedge clk);
    #1;
    start    = st;
    load     = ld;
    host_si  = hs;
    so_ready = rdy;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom));
  endtask

  // Launch one operation and wait (bounded) for done; lat is edges from start sample to done
  task automatic runOp(input logic ld, input logic [N-1:0] d, input bit bp, input bit hold_start,
                       output int lat);
    int k;
    @(posedge clk);
    #1;
    cell_d   = d;
    start    = 1'b1;
    load     = ld;
    so_ready = 1'b1;
    host_si  = host_seq[0];
    @(posedge clk);
    #1;
    k     = cyc;
    start = hold_start;
    load  = 1'($urandom);
    lat   = -1;
    for (int i = 0; i < 60; i++) begin
      so_ready = bp ? bp_pat[i % 4] : 1'b1;
      host_si  = host_seq[acc_cnt % N];
      #2;
      if (done) begin
        lat = cyc - k;
        break;
      end
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    so_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int dc0;
    $display("[TB] scan_chain_ctrl bench starting");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idleCycles(3);

    // Read 0xA5 at full rate: one capture cycle, MSB first, chain restored
    runOp(1'b0, 8'hA5, 1'b0, 1'b0, lat);
    checkOutput("read_latency", lat, 9);
    checkOutput("read_cap_cycles", cap_cycles, 1);
    checkOutput("read_word", act_word, 8'hA5);
    checkOutput("read_bitcnt_at_done", bit_cnt, 8);
    checkOutput("read_parity_a5", parity, 1'b0);
    idleCycles(2);
    checkOutput("read_chain_kept", cells, 8'hA5);

    // Write 0x3C while the old 0xA5 streams out; no capture
    runOp(1'b1, 8'h00, 1'b0, 1'b0, lat);
    checkOutput("write_latency", lat, 8);
    checkOutput("write_cap_cycles", cap_cycles, 0);
    checkOutput("write_old_word", act_word, 8'hA5);
    idleCycles(2);
    checkOutput("write_chain", cells, 8'h3C);

    // Read under backpressure; per-cycle checks cover stalls
    runOp(1'b0, 8'hA5, 1'b1, 1'b0, lat);
    checkOutput("bp_done_seen", lat >= 0, 1);
    checkOutput("bp_word", act_word, 8'hA5);
    checkOutput("bp_bitcnt_at_done", bit_cnt, 8);
    idleCycles(2);
    checkOutput("bp_chain_kept", cells, 8'hA5);

    // Start held high for the whole read of 0xA4: ignored while busy, one done only
    dc0 = done_count;
    runOp(1'b0, 8'hA4, 1'b0, 1'b1, lat);
    checkOutput("busy_start_latency", lat, 9);
`ifdef SCAN_PARITY_EN
    checkOutput("read_parity_a4", parity, 1'b1);
`else
    checkOutput("read_parity_a4", parity, 1'b0);
`endif
    idleCycles(4);
    checkOutput("busy_start_one_done", done_count - dc0, 1);
    checkOutput("busy_start_idle", busy, 1'b0);

    // Reset in the middle of a read, after three accepted bits
    dc0 = done_count;
    @(posedge clk);
    #1;
    cell_d = 8'hFF; start = 1'b1; load = 1'b0; so_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (acc_cnt == 3) break;
      @(posedge clk);
      #1;
    end
    checkOutput("mid_bitcnt", bit_cnt, 3);
    rst = 1'b1;
    #1;
    checkOutput("rst_chain_cap", chain_cap, 1'b0);
    checkOutput("rst_chain_shift", chain_shift, 1'b0);
    checkOutput("rst_so_valid", so_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_bit_cnt", bit_cnt, 0);
    checkOutput("rst_parity", parity, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idleCycles(12);
    checkOutput("rst_no_done", done_count - dc0, 0);

    // Randomised traffic checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (m_idle && ($urandom % 8 == 0)) cell_d = N'($urandom);
      start    = ($urandom % 6 == 0);
      load     = 1'($urandom);
      host_si  = 1'($urandom);
      so_ready = ($urandom % 4 != 0);
      rst      = ($urandom % 400 == 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    idleCycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
